// File: rtl/mario_dash_pkg.sv
// Shared definitions for the Mario-Dash player logic.
//   - Player sprite and screen geometry.
//   - Game-state encoding presented on game_state.
//   - Motion sequencer state enum.
//   - clamp_coord(): saturates a signed intermediate coordinate into [0, hi].
package mario_dash_pkg;

  localparam int PLAYER_W  = 16;
  localparam int PLAYER_H  = 16;
  localparam int SCREEN_W  = 640;
  localparam int COORD_MAX = 1023;  // largest value a 10-bit coordinate can hold

  typedef enum logic [1:0] {
    GS_PLAYING = 2'b00,
    GS_WON     = 2'b01,
    GS_DEAD    = 2'b10
  } game_state_e;

  // One state per cycle: probe X, check X, probe Y, check Y, evaluate events.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PX,
    ST_CX,
    ST_PY,
    ST_CY,
    ST_EV
  } motion_state_e;

  function automatic logic [9:0] clamp_coord(input logic signed [11:0] v,
                                             input logic [9:0]        hi);
    if (v < 12'sd0) begin
      return 10'd0;
    end else if (v > $signed({2'b00, hi})) begin
      return hi;
    end else begin
      return v[9:0];
    end
  endfunction

endpackage

// File: rtl/player_motion_ctrl.sv
// Per-frame player physics sequencer.
// On an accepted frame_tick the block walks IDLE->PX->CX->PY->CY->EV->IDLE,
// presenting registered probe coordinates to the external combinational
// collision block and committing the position, vertical speed and game state
// from its answers. All outputs settle 5 cycles after the accepted tick.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   frame_tick               one-cycle pulse per video frame
//   btn_left/right/jump      level buttons, latched when a frame starts
//   btn_restart              level; honoured in IDLE while WON or DEAD
//   probe_x, probe_y         coordinates presented to the collision block
//   on_ground, support_y,
//   hit_ceiling, hit_left_wall,
//   hit_right_wall,
//   at_goal_region, in_lava  collision results for the current probe
//   player_x, player_y       committed position
//   game_state               00 PLAYING, 01 WON, 10 DEAD
//   busy                     high while a frame is being processed
module player_motion_ctrl
  import mario_dash_pkg::*;
#(
  parameter logic [9:0] SPAWN_X   = 10'd20,
  parameter logic [9:0] SPAWN_Y   = 10'd344,
  parameter int         RUN_SPEED = 2,
  parameter int         JUMP_V    = 8,
  parameter int         MAX_FALL  = 3,   // must stay <= 3: landing window of the collision block
  parameter logic [9:0] LAVA_Y    = 10'd380
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_jump,
  input  logic       btn_restart,
  output logic [9:0] probe_x,
  output logic [9:0] probe_y,
  input  logic       on_ground,
  input  logic [9:0] support_y,
  input  logic       hit_ceiling,
  input  logic       hit_left_wall,
  input  logic       hit_right_wall,
  input  logic       at_goal_region,
  input  logic       in_lava,
  output logic [9:0] player_x,
  output logic [9:0] player_y,
  output logic [1:0] game_state,
  output logic       busy
);

  localparam logic signed [11:0] RUN_STEP = 12'(RUN_SPEED);
  localparam logic signed [4:0]  JUMP_VY  = 5'(-JUMP_V);
  localparam logic signed [4:0]  FALL_VY  = 5'(MAX_FALL);
  localparam logic [9:0]         X_MAX    = 10'(SCREEN_W - PLAYER_W);
  localparam logic [9:0]         Y_MAX    = 10'(COORD_MAX - PLAYER_H);

  motion_state_e     state_q, state_d;
  game_state_e       gs_q, gs_d;
  logic [9:0]        x_q, x_d, y_q, y_d;
  logic [9:0]        px_q, px_d, py_q, py_d;
  logic signed [4:0] vy_q, vy_d;
  logic              grounded_q, grounded_d;
  logic              left_q, left_d, right_q, right_d, jump_q, jump_d;

  logic              move_left, move_right;
  logic signed [11:0] x_ext, y_ext;
  logic signed [4:0] vy_next;
  logic [9:0]        y_commit;

  // Both or neither direction held means no horizontal intent.
  assign move_right = right_q & ~left_q;
  assign move_left  = left_q & ~right_q;
  assign x_ext      = $signed({2'b00, x_q});
  assign y_ext      = $signed({2'b00, y_q});

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; the asynchronous reset clears any half-finished frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      gs_q       <= GS_PLAYING;
      x_q        <= SPAWN_X;
      y_q        <= SPAWN_Y;
      px_q       <= SPAWN_X;
      py_q       <= SPAWN_Y;
      vy_q       <= 5'sd0;
      grounded_q <= 1'b1;
      left_q     <= 1'b0;
      right_q    <= 1'b0;
      jump_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      gs_q       <= gs_d;
      x_q        <= x_d;
      y_q        <= y_d;
      px_q       <= px_d;
      py_q       <= py_d;
      vy_q       <= vy_d;
      grounded_q <= grounded_d;
      left_q     <= left_d;
      right_q    <= right_d;
      jump_q     <= jump_d;
    end
  end

  always_comb begin
    // NOTE: every signal written below gets a hold/default value first, so no
    // path through the case statement can infer a latch.
    state_d    = state_q;
    gs_d       = gs_q;
    x_d        = x_q;
    y_d        = y_q;
    px_d       = px_q;
    py_d       = py_q;
    vy_d       = vy_q;
    grounded_d = grounded_q;
    left_d     = left_q;
    right_d    = right_q;
    jump_d     = jump_q;
    vy_next    = vy_q;
    y_commit   = y_q;

    unique case (state_q)
      ST_IDLE: begin
        if (gs_q != GS_PLAYING) begin
          // Frozen until restart; ticks are ignored.
          if (btn_restart) begin
            x_d        = SPAWN_X;
            y_d        = SPAWN_Y;
            px_d       = SPAWN_X;
            py_d       = SPAWN_Y;
            vy_d       = 5'sd0;
            grounded_d = 1'b1;
            gs_d       = GS_PLAYING;
          end
        end else if (frame_tick) begin
          left_d  = btn_left;
          right_d = btn_right;
          jump_d  = btn_jump;
          if (btn_right && !btn_left) begin
            px_d = clamp_coord(x_ext + RUN_STEP, X_MAX);
          end else if (btn_left && !btn_right) begin
            px_d = clamp_coord(x_ext - RUN_STEP, X_MAX);
          end else begin
            px_d = x_q;
          end
          py_d    = y_q;
          state_d = ST_PX;
        end
      end

      ST_PX: state_d = ST_CX;

      ST_CX: begin
        // Wall flags only matter in the direction of travel.
        if (!((move_right && hit_right_wall) || (move_left && hit_left_wall))) begin
          x_d = px_q;
        end
        if (jump_q && grounded_q) begin
          vy_next = JUMP_VY;
        end else if (vy_q >= FALL_VY) begin
          vy_next = FALL_VY;
        end else begin
          vy_next = vy_q + 5'sd1;
        end
        vy_d    = vy_next;
        px_d    = x_d;
        py_d    = clamp_coord(y_ext + $signed({{7{vy_next[4]}}, vy_next}), Y_MAX);
        state_d = ST_PY;
      end

      ST_PY: state_d = ST_CY;

      ST_CY: begin
        if (!vy_q[4] && on_ground) begin
          y_commit   = support_y - 10'(PLAYER_H);
          vy_d       = 5'sd0;
          grounded_d = 1'b1;
        end else if (vy_q[4] && hit_ceiling) begin
          y_commit   = y_q;
          vy_d       = 5'sd0;
          grounded_d = 1'b0;
        end else begin
          y_commit   = py_q;
          grounded_d = 1'b0;
        end
        y_d     = y_commit;
        px_d    = x_q;
        py_d    = y_commit;
        state_d = ST_EV;
      end

      ST_EV: begin
        // Probe now holds the committed position, so goal/lava refer to it.
        if (at_goal_region) begin
          gs_d = GS_WON;
        end else if (in_lava ||
                     (!grounded_q && (({1'b0, y_q} + 11'(PLAYER_H)) >= {1'b0, LAVA_Y}))) begin
          gs_d = GS_DEAD;
        end
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign probe_x    = px_q;
  assign probe_y    = py_q;
  assign player_x   = x_q;
  assign player_y   = y_q;
  assign game_state = gs_q;
  assign busy       = (state_q != ST_IDLE);

endmodule
